// File: rtl/park_pkg.sv
// Shared definitions for the parking gate controller: FSM state encoding,
// lane direction constants and default sizing.
// Imported by park_rr_arb and park_gate_ctrl.
package park_pkg;

    // Barrier sequencing phases.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RAISE = 2'd1,
        ST_PASS  = 2'd2,
        ST_LOWER = 2'd3
    } state_e;

    // Lane direction: which lane owns the current barrier cycle.
    typedef enum logic {
        DIR_IN  = 1'b0,
        DIR_OUT = 1'b1
    } dir_e;

    localparam int DEF_CAPACITY    = 9;
    localparam int DEF_OPEN_CYCLES = 8;

    // Round-robin helper: the direction that did not win last time.
    function automatic dir_e other_dir(input dir_e d);
        return (d == DIR_IN) ? DIR_OUT : DIR_IN;
    endfunction

endpackage : park_pkg

// File: rtl/park_gate_ctrl_if.sv
// Lane-side bundle for the parking gate controller.
// master: lane sensors/debouncers (drive requests and car_pass, observe grants,
//         barrier command, occupancy and flags); slave: the controller itself.
interface park_gate_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             entry_req;   // entry lane request, level, held until grant_in
    logic             exit_req;    // exit lane request, level, held until grant_out
    logic             car_pass;    // single-cycle pulse when a car clears the gate
    logic             grant_in;    // one-cycle pulse: entry granted
    logic             grant_out;   // one-cycle pulse: exit granted
    logic             gate_cmd;    // barrier up command
    logic             busy;        // controller not idle
    logic [CNT_W-1:0] occupancy;   // current car count (feeds the display path)
    logic             full;        // occupancy == CAPACITY
    logic             empty;       // occupancy == 0
    logic             timeout;     // one-cycle pulse on pass-phase abort

    modport master (
        output entry_req, exit_req, car_pass,
        input  grant_in, grant_out, gate_cmd, busy, occupancy, full, empty, timeout
    );

    modport slave (
        input  entry_req, exit_req, car_pass,
        output grant_in, grant_out, gate_cmd, busy, occupancy, full, empty, timeout
    );

endinterface : park_gate_ctrl_if

// File: rtl/park_rr_arb.sv
// Two-requester round-robin arbiter (entry vs exit lane).
// Latency: winner is combinational from the requests; rr_last updates on the upd edge.
// Backpressure: none; the caller strobes upd only when it actually consumes the winner.
// Ports: clk, reset (async, active-high), req_in/req_out (eligible requests),
//        upd (commit winner), win_vld/win_dir (winner present / its direction).
module park_rr_arb
    import park_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_in,
    input  logic req_out,
    input  logic upd,
    output logic win_vld,
    output dir_e win_dir
);

    dir_e rr_last_q;
    dir_e rr_last_d;

    always_comb begin
        win_vld = req_in | req_out;
        win_dir = DIR_IN;
        if (req_in && req_out) begin
            // Tie: the lane that did not win last time goes first.
            win_dir = other_dir(rr_last_q);
        end else if (req_out) begin
            win_dir = DIR_OUT;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (upd && win_vld) begin
            rr_last_d = win_dir;
        end
    end

    // Reset to OUT so the very first tie is awarded to the entry lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_last_q <= DIR_OUT;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end

endmodule : park_rr_arb

// File: rtl/park_gate_ctrl.sv
// Single-lane parking gate controller: arbitrates entry/exit, sequences the barrier, owns occupancy.
// Latency: grant and gate_cmd one edge after an eligible request in IDLE; occupancy one edge after car_pass.
// Backpressure: requests are not queued; an ineligible or busy-time request is simply not granted.
//
// Ports: clk, reset (async, active-high), bus (park_gate_ctrl_if.slave) carrying
//        entry_req/exit_req/car_pass in and grant_in/grant_out/gate_cmd/busy/
//        occupancy/full/empty/timeout out.
// Optional macro PARK_TIMEOUT_EN: bounds the PASS phase to TIMEOUT_CYCLES and
// pulses timeout on abort; without it PASS waits for car_pass indefinitely.
module park_gate_ctrl
    import park_pkg::*;
#(
    parameter int CAPACITY       = DEF_CAPACITY,
    parameter int CNT_W          = 4,
    parameter int OPEN_CYCLES    = DEF_OPEN_CYCLES,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TIMER_W        = 10
) (
    input  logic             clk,
    input  logic             reset,
    park_gate_ctrl_if.slave  bus
);

    // Reject configurations the counters cannot represent.
    if (((2 ** CNT_W) <= CAPACITY) || (OPEN_CYCLES < 1) ||
        ((2 ** TIMER_W) < OPEN_CYCLES) || ((2 ** TIMER_W) < TIMEOUT_CYCLES)) begin : g_bad_cfg
        $error("park_gate_ctrl: inconsistent CAPACITY/CNT_W/OPEN_CYCLES/TIMEOUT_CYCLES/TIMER_W");
    end

    localparam logic [CNT_W-1:0]   OCC_MAX    = CNT_W'(CAPACITY);
    localparam logic [TIMER_W-1:0] OPEN_LAST  = TIMER_W'(OPEN_CYCLES - 1);
`ifdef PARK_TIMEOUT_EN
    localparam logic [TIMER_W-1:0] PASS_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
`endif

    state_e             state_q,     state_d;
    dir_e               dir_q,       dir_d;
    logic [TIMER_W-1:0] timer_q,     timer_d;
    logic [CNT_W-1:0]   occ_q,       occ_d;
    logic               grant_in_q,  grant_in_d;
    logic               grant_out_q, grant_out_d;
`ifdef PARK_TIMEOUT_EN
    logic               timeout_q,   timeout_d;
`endif

    logic full_w;
    logic empty_w;
    logic is_idle;
    logic elig_in;
    logic elig_out;
    logic win_vld;
    dir_e win_dir;
    logic arb_upd;

    // Flags come straight from the registered count.
    assign full_w  = (occ_q == OCC_MAX);
    assign empty_w = (occ_q == '0);
    assign is_idle = (state_q == ST_IDLE);

    // Eligibility keeps occupancy inside 0..CAPACITY; only IDLE arbitrates.
    assign elig_in  = is_idle && bus.entry_req && !full_w;
    assign elig_out = is_idle && bus.exit_req  && !empty_w;

    park_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req_in  (elig_in),
        .req_out (elig_out),
        .upd     (arb_upd),
        .win_vld (win_vld),
        .win_dir (win_dir)
    );

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        timer_d     = timer_q;
        occ_d       = occ_q;
        grant_in_d  = 1'b0;
        grant_out_d = 1'b0;
        arb_upd     = 1'b0;
`ifdef PARK_TIMEOUT_EN
        timeout_d   = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d     = ST_RAISE;
                    dir_d       = win_dir;
                    timer_d     = '0;
                    arb_upd     = 1'b1;
                    // Registered so the grant pulse lands in the first RAISE cycle.
                    grant_in_d  = (win_dir == DIR_IN);
                    grant_out_d = (win_dir == DIR_OUT);
                end
            end

            ST_RAISE: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = ST_PASS;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            ST_PASS: begin
                // car_pass takes priority over an expiring pass timer.
                if (bus.car_pass) begin
                    state_d = ST_LOWER;
                    timer_d = '0;
                    // Saturating update as a guard behind eligibility.
                    if (dir_q == DIR_IN) begin
                        if (occ_q != OCC_MAX) begin
                            occ_d = occ_q + CNT_W'(1);
                        end
                    end else begin
                        if (occ_q != '0) begin
                            occ_d = occ_q - CNT_W'(1);
                        end
                    end
                end
`ifdef PARK_TIMEOUT_EN
                else if (timer_q == PASS_LAST) begin
                    state_d   = ST_LOWER;
                    timer_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
`endif
            end

            ST_LOWER: begin
                if (timer_q == OPEN_LAST) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dir_q       <= DIR_IN;
            timer_q     <= '0;
            occ_q       <= '0;
            grant_in_q  <= 1'b0;
            grant_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            timer_q     <= timer_d;
            occ_q       <= occ_d;
            grant_in_q  <= grant_in_d;
            grant_out_q <= grant_out_d;
        end
    end

`ifdef PARK_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // Barrier is up through RAISE and PASS; decoding it from the state register
    // means the async reset drops it immediately.
    assign bus.gate_cmd  = (state_q == ST_RAISE) || (state_q == ST_PASS);
    assign bus.busy      = !is_idle;
    assign bus.grant_in  = grant_in_q;
    assign bus.grant_out = grant_out_q;
    assign bus.occupancy = occ_q;
    assign bus.full      = full_w;
    assign bus.empty     = empty_w;

endmodule : park_gate_ctrl

// File: tb/tb_park_gate_ctrl.sv
// Directed bench for park_gate_ctrl with CAPACITY=3, OPEN_CYCLES=4, TIMEOUT_CYCLES=20.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_park_gate_ctrl;

    localparam int CAP   = 3;
    localparam int OPEN  = 4;
    localparam int TOUT  = 20;

    logic clk;
    logic reset;

    park_gate_ctrl_if #(.CNT_W(4)) bus ();

    park_gate_ctrl #(
        .CAPACITY       (CAP),
        .CNT_W          (4),
        .OPEN_CYCLES    (OPEN),
        .TIMEOUT_CYCLES (TOUT),
        .TIMER_W        (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int occ_m    = 0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Starts at the negedge where the request was raised one edge earlier.
    task automatic finish_txn(input bit is_in, input int pass_wait, input int exp_occ);
        @(negedge clk);
        chk_eq("grant_in_pulse",  32'(bus.grant_in),  is_in ? 1 : 0);
        chk_eq("grant_out_pulse", 32'(bus.grant_out), is_in ? 0 : 1);
        chk_eq("gate_up_raise",   32'(bus.gate_cmd),  1);
        chk_eq("busy_raise",      32'(bus.busy),      1);
        if (is_in) bus.entry_req = 1'b0;
        else       bus.exit_req  = 1'b0;
        repeat (OPEN - 1) @(negedge clk);
        chk_eq("gate_up_raise_end", 32'(bus.gate_cmd), 1);
        chk_eq("grant_single",      32'(bus.grant_in | bus.grant_out), 0);
        @(negedge clk);
        chk_eq("gate_up_pass", 32'(bus.gate_cmd), 1);
        repeat (pass_wait) @(negedge clk);
        chk_eq("gate_up_pass_end", 32'(bus.gate_cmd), 1);
        chk_eq("no_timeout_pass",  32'(bus.timeout),  0);
        bus.car_pass = 1'b1;
        @(negedge clk);
        bus.car_pass = 1'b0;
        chk_eq("occupancy",  32'(bus.occupancy), exp_occ);
        chk_eq("full",       32'(bus.full),      (exp_occ == CAP) ? 1 : 0);
        chk_eq("empty",      32'(bus.empty),     (exp_occ == 0) ? 1 : 0);
        chk_eq("gate_lower", 32'(bus.gate_cmd),  0);
        chk_eq("busy_lower", 32'(bus.busy),      1);
        repeat (OPEN - 1) @(negedge clk);
        chk_eq("busy_lower_end",   32'(bus.busy), 1);
        chk_eq("no_grant_lower",   32'(bus.grant_in | bus.grant_out), 0);
        @(negedge clk);
        chk_eq("idle_after_lower", 32'(bus.busy), 0);
    endtask

    task automatic req_and_finish(input bit is_in, input int pass_wait, input int exp_occ);
        @(negedge clk);
        if (is_in) bus.entry_req = 1'b1;
        else       bus.exit_req  = 1'b1;
        finish_txn(is_in, pass_wait, exp_occ);
    endtask

    initial begin
        reset         = 1'b1;
        bus.entry_req = 1'b0;
        bus.exit_req  = 1'b0;
        bus.car_pass  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state.
        chk_eq("rst_grant_in",  32'(bus.grant_in),  0);
        chk_eq("rst_grant_out", 32'(bus.grant_out), 0);
        chk_eq("rst_gate",      32'(bus.gate_cmd),  0);
        chk_eq("rst_busy",      32'(bus.busy),      0);
        chk_eq("rst_occ",       32'(bus.occupancy), 0);
        chk_eq("rst_full",      32'(bus.full),      0);
        chk_eq("rst_empty",     32'(bus.empty),     1);
        chk_eq("rst_timeout",   32'(bus.timeout),   0);

        // Single entry with a two-cycle wait in PASS: occupancy 0 -> 1.
        req_and_finish(1'b1, 2, 1);
        // Build occupancy 2, then an exit leaves rr_last = OUT at occupancy 1.
        req_and_finish(1'b1, 0, 2);
        req_and_finish(1'b0, 1, 1);

        // Both held: entry first (opposite of rr_last), exit on the next IDLE cycle.
        @(negedge clk);
        bus.entry_req = 1'b1;
        bus.exit_req  = 1'b1;
        finish_txn(1'b1, 0, 2);
        finish_txn(1'b0, 0, 1);

        // Fill the lot.
        req_and_finish(1'b1, 0, 2);
        req_and_finish(1'b1, 0, 3);
        chk_eq("full_at_cap", 32'(bus.full), 1);

        // Entry at capacity is refused while held.
        @(negedge clk);
        bus.entry_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("full_no_grant_in", 32'(bus.grant_in), 0);
            chk_eq("full_stay_idle",   32'(bus.busy),     0);
        end
        // Exit still served; the held entry wins on the next IDLE cycle.
        bus.exit_req = 1'b1;
        finish_txn(1'b0, 0, 2);
        finish_txn(1'b1, 0, 3);

        // Drain to empty.
        req_and_finish(1'b0, 0, 2);
        req_and_finish(1'b0, 0, 1);
        req_and_finish(1'b0, 0, 0);

        // Exit at empty is refused; spurious car_pass in IDLE is ignored.
        @(negedge clk);
        bus.exit_req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_eq("empty_no_grant_out", 32'(bus.grant_out), 0);
            chk_eq("empty_stay_idle",    32'(bus.busy),      0);
        end
        bus.exit_req = 1'b0;
        bus.car_pass = 1'b1;
        @(negedge clk);
        bus.car_pass = 1'b0;
        @(negedge clk);
        chk_eq("spurious_pass_occ",   32'(bus.occupancy), 0);
        chk_eq("spurious_pass_empty", 32'(bus.empty),     1);
        occ_m = 0;

`ifdef PARK_TIMEOUT_EN
        // No car in PASS: abort after TOUT cycles, no occupancy change.
        bus.entry_req = 1'b1;
        @(negedge clk);
        chk_eq("to_grant_in", 32'(bus.grant_in), 1);
        bus.entry_req = 1'b0;
        repeat (OPEN) @(negedge clk);
        repeat (TOUT - 1) @(negedge clk);
        chk_eq("to_gate_last_pass", 32'(bus.gate_cmd), 1);
        chk_eq("to_not_yet",        32'(bus.timeout),  0);
        @(negedge clk);
        chk_eq("to_pulse",     32'(bus.timeout),   1);
        chk_eq("to_gate_down", 32'(bus.gate_cmd),  0);
        chk_eq("to_occ_same",  32'(bus.occupancy), occ_m);
        @(negedge clk);
        chk_eq("to_pulse_end", 32'(bus.timeout), 0);
        repeat (OPEN - 2) @(negedge clk);
        chk_eq("to_busy_lower", 32'(bus.busy), 1);
        @(negedge clk);
        chk_eq("to_idle", 32'(bus.busy), 0);
`else
        // Without the timeout option PASS waits well past TOUT cycles.
        occ_m = 1;
        req_and_finish(1'b1, TOUT + 5, occ_m);
`endif

        while (occ_m < 2) begin
            occ_m++;
            req_and_finish(1'b1, 0, occ_m);
        end

        // Reset asserted mid-PASS at occupancy 2.
        @(negedge clk);
        bus.entry_req = 1'b1;
        @(negedge clk);
        chk_eq("mid_grant_in", 32'(bus.grant_in), 1);
        bus.entry_req = 1'b0;
        repeat (OPEN) @(negedge clk);
        chk_eq("mid_pass_gate", 32'(bus.gate_cmd),  1);
        chk_eq("mid_pass_occ",  32'(bus.occupancy), 2);
        #2 reset = 1'b1;
        #1;
        chk_eq("async_rst_gate", 32'(bus.gate_cmd),  0);
        chk_eq("async_rst_occ",  32'(bus.occupancy), 0);
        chk_eq("async_rst_busy", 32'(bus.busy),      0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_eq("post_rst_idle",  32'(bus.busy),     0);
        chk_eq("post_rst_empty", 32'(bus.empty),    1);
        chk_eq("post_rst_gate",  32'(bus.gate_cmd), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_park_gate_ctrl

// File: doc/park_gate_ctrl.md
Name: park_gate_ctrl

Overview:
Controller for a single-lane parking gate shared between the entry and exit lanes. It arbitrates entry and exit requests and sequences the barrier through raise, pass and lower phases. It also owns the lot occupancy count and the full/empty flags. It sits between the lane sensor FSM/debouncers and the seven-segment display path; its occupancy output feeds the display in place of a standalone counter.

Parameters:
CAPACITY, 9, maximum number of cars; entry is refused at this occupancy
CNT_W, 4, occupancy width; must satisfy 2**CNT_W > CAPACITY
OPEN_CYCLES, 8, clock cycles spent in each of the raise and lower phases (must be >= 1)
TIMEOUT_CYCLES, 1000, cycles allowed in the pass phase (used only with PARK_TIMEOUT_EN)
TIMER_W, 10, phase timer width; must hold max(OPEN_CYCLES, TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
entry_req  in  1  entry-lane request, level; held until grant_in
exit_req  in  1  exit-lane request, level; held until grant_out
car_pass  in  1  passage sensor, single-cycle pulse when a car clears the gate
grant_in  out  1  one-cycle pulse: entry granted
grant_out  out  1  one-cycle pulse: exit granted
gate_cmd  out  1  barrier up command
busy  out  1  high whenever the state is not IDLE
occupancy  out  CNT_W  current car count
full  out  1  occupancy == CAPACITY
empty  out  1  occupancy == 0
timeout  out  1  one-cycle pulse on pass-phase abort (tied 0 without the macro)

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - state = IDLE; all outputs are 0 except empty = 1.
  - occupancy = 0, timer = 0, rr_last = EXIT (so the first tie goes to entry).
- Eligibility:
  - Entry is eligible when entry_req is high and full is low.
  - Exit is eligible when exit_req is high and empty is low.
  - An ineligible request is ignored and receives no grant.
- Arbitration (IDLE only):
  - If exactly one request is eligible, it wins.
  - If both are eligible, the winner is the direction opposite rr_last (round-robin). rr_last updates to the winner on grant.
- States and transitions:
  - IDLE: when a winner exists, go to RAISE. grant_in or grant_out pulses in the first RAISE cycle, and dir latches the winner.
  - RAISE: gate_cmd = 1. Stay for OPEN_CYCLES cycles, then go to PASS.
  - PASS: gate_cmd = 1. On car_pass = 1, go to LOWER and update occupancy on the same edge: +1 if dir = IN, -1 if dir = OUT.
  - LOWER: gate_cmd = 0. Stay for OPEN_CYCLES cycles, then go to IDLE.
- Latency:
  - Request high at edge N gives grant and gate_cmd high after edge N+1.
  - car_pass at edge M gives the new occupancy after M+1.
  - Minimum full cycle is 2*OPEN_CYCLES + 2 clocks, request to IDLE.
- Derived flags: full and empty are combinational from the registered occupancy. Occupancy never leaves the range 0..CAPACITY; eligibility guarantees this, and the update also saturates as a guard.
- car_pass outside PASS is ignored and never changes occupancy.
- Requests arriving while busy are not queued. They are arbitrated on the first IDLE cycle only if still held.
- Full lot: exit requests are still served. Once an exit completes, a waiting entry wins on the next IDLE cycle.
- Reset mid-operation: reset asserted in any state forces IDLE with gate_cmd = 0 immediately (asynchronous) and clears occupancy.

Optional Feature:
PARK_TIMEOUT_EN
- Defined: the timer counts in PASS. At TIMEOUT_CYCLES without car_pass, the block goes to LOWER with no occupancy change and pulses timeout for one cycle. If car_pass coincides with the final timeout cycle, car_pass wins and timeout does not pulse.
- Undefined: PASS waits indefinitely; timeout is constant 0 and the PASS timer logic is absent.

Decomposition:
- Shared package park_pkg:
  - state encoding (IDLE, RAISE, PASS, LOWER)
  - direction constants DIR_IN and DIR_OUT
  - default CAPACITY and OPEN_CYCLES
- Sub-module park_rr_arb: two-requester round-robin arbiter, holding rr_last, a winner output and an update strobe.
- The FSM, phase timer and occupancy register stay in the top of park_gate_ctrl.

Test Plan:
Bench parameters: CAPACITY=3, OPEN_CYCLES=4, TIMEOUT_CYCLES=20.
- Reset then entry_req=1: grant_in pulses 1 cycle after, gate_cmd high for 4 RAISE cycles plus the PASS cycles. car_pass then gives occupancy=1 and empty=0, gate_cmd drops, and busy is released after 4 more cycles.
- Both requests held with occupancy=1: grants alternate, first in and then out. Occupancy sequence is 1->2->1.
- Three entries: occupancy=3 and full=1. A further entry_req gets no grant and busy stays 0. exit_req is then granted, occupancy=2, and the pending entry is granted on the next IDLE cycle.
- exit_req at occupancy=0: no grant. A spurious car_pass in IDLE leaves occupancy=0.
- With PARK_TIMEOUT_EN, no car_pass in PASS: timeout pulses after 20 cycles, occupancy is unchanged, and the block returns to IDLE after LOWER.
- Reset asserted mid-PASS at occupancy=2: gate_cmd=0 and occupancy=0 asynchronously, and the block is in IDLE on release.
